booth_result_bcd: RTL and testbench
===================================

# booth_result_bcd

Sequential binary-to-BCD converter downstream of `top_booth_mult`. Captures the signed product each time the multiplier raises `ready`. Converts the magnitude to packed BCD with a shift-add-3 (double-dabble) loop, one bit per clock, and presents a sign flag plus decimal digits for the display/readout stage. Conversion latency is independent of the operand value.

## Interface
- `WORD_LENGTH`, 16, multiplier operand width; product width is 2*WORD_LENGTH.
- `DIGITS`, 10, number of BCD digits produced; must cover 2^(2*WORD_LENGTH-1) (10 for 32-bit).
- `clk` input 1, system clock, all logic on rising edge.
- `rst` input 1, synchronous, active-low reset.
- `mult_result` input 2*WORD_LENGTH, signed two's-complement product from the multiplier.
- `mult_ready` input 1, multiplier ready level; a 0->1 transition marks a new valid product.
- `bcd` output 4*DIGITS, packed BCD magnitude, digit 0 (units) in bits [3:0].
- `sign` output 1, 1 = product negative.
- `busy` output 1, conversion in progress.
- `done` output 1, one-cycle pulse when `bcd`/`sign` update.

## Operation
- Reset (rst=0 at a clock edge): state IDLE, `bcd`=0, `sign`=0, `busy`=0, `done`=0, bit counter=0, scratch registers=0, internal `ready_q`=1.
- `ready_q` registers `mult_ready` every cycle; trigger = `mult_ready & ~ready_q`.
- Reset value 1 on `ready_q` means a `mult_ready` held high through reset release does not trigger; a fresh rising edge is required.
- States: IDLE, CONV.
- IDLE, trigger=1:
  - load magnitude = `mult_result[MSB] ? -mult_result : mult_result`, taken as unsigned 2*WORD_LENGTH bits;
  - store sign = `mult_result[MSB]` into a pending register;
  - clear BCD scratch and counter; `busy`<=1; go to CONV.
- IDLE, trigger=0: hold all outputs; `done`<=0.
- CONV, each edge:
  - every scratch digit >= 5 gets +3;
  - shift {scratch, magnitude} left by 1;
  - counter+1.
- CONV, edge where counter = 2*WORD_LENGTH-1 (final shift):
  - `bcd` <= final scratch; `sign` <= pending sign;
  - `done`<=1; `busy`<=0; go to IDLE.
- Most-negative input (0x80000000): the negation wraps to 0x80000000; the unsigned interpretation gives 2147483648. No special case.
- Zero: `bcd`=0, `sign`=0.
- Triggers while in CONV are ignored and not queued. `ready_q` still tracks, so that edge is consumed.
- `bcd`/`sign` hold the last completed conversion until the next `done`. They never show partial results.
- Reset mid-conversion aborts immediately; all outputs return to reset values.

## Timing
- Edge E0 (IDLE, trigger sampled): capture; `busy`=1 after E0.
- Edges E1..E(2*WORD_LENGTH): shift iterations (32 for default).
- After E32: `bcd`/`sign` valid, `done`=1 for exactly one cycle, `busy`=0.
- Total latency: 33 clock edges from trigger edge to `done` (default parameters).
- `busy` and `done` are never high in the same cycle.
- Earliest next trigger is the edge after E32 (back-to-back capable).
- Throughput: one conversion per 33 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `mult_result`=100 (10*10) with a `mult_ready` rising edge -> 33 edges later `done` pulses once; `bcd`=0x0000000100, `sign`=0. `busy` high for exactly 32 cycles.
- `mult_result`=0xFFFFFFFF (-1) -> `bcd`=0x0000000001, `sign`=1. Then 0x80000000 -> `bcd`=0x2147483648, `sign`=1. Then 0x7FFFFFFF -> `bcd`=0x2147483647, `sign`=0.
- `mult_result`=0 -> `bcd`=0, `sign`=0, `done` pulse at the same 33-edge latency.
- Second `mult_ready` rising edge 10 cycles into a conversion, with a new `mult_result` -> ignored. Only one `done`, carrying the first value. A later fresh edge converts normally.
- `mult_ready` held high for 100 cycles -> exactly one conversion and one `done`. `mult_ready` high across reset release -> no conversion until it drops and rises again.
- `rst`=0 at CONV iteration 15 -> next cycle `bcd`=0, `sign`=0, `busy`=0, `done`=0. A subsequent trigger with 12345 -> `bcd`=0x0000012345 after 33 edges.

Source files
------------

// File: rtl/booth_result_bcd_if.sv
// booth_result_bcd_if
//   Groups the product handshake from the multiplier and the BCD result
//   presented to the readout stage.
//   mult_result : signed two's-complement product (2*WORD_LENGTH bits)
//   mult_ready  : multiplier ready level, 0->1 marks a new product
//   bcd         : packed BCD magnitude, digit 0 (units) in [3:0]
//   sign        : 1 = product negative
//   busy        : conversion in progress
//   done        : one-cycle pulse when bcd/sign update
//   master = product source / result consumer, slave = converter.
interface booth_result_bcd_if #(
    parameter int WORD_LENGTH = 16,
    parameter int DIGITS      = 10
);
    logic [2*WORD_LENGTH-1:0] mult_result;
    logic                     mult_ready;
    logic [4*DIGITS-1:0]      bcd;
    logic                     sign;
    logic                     busy;
    logic                     done;

    modport master (
        output mult_result, mult_ready,
        input  bcd, sign, busy, done
    );

    modport slave (
        input  mult_result, mult_ready,
        output bcd, sign, busy, done
    );
endinterface

// File: rtl/booth_result_bcd.sv
// booth_result_bcd
//   Captures the signed product on each rising edge of mult_ready and
//   converts its magnitude to packed BCD with a shift-add-3 loop, one bit
//   per clock. Latency is fixed at 2*WORD_LENGTH+1 edges from trigger to done.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : booth_result_bcd_if slave (mult_result/mult_ready in,
//         bcd/sign/busy/done out, all outputs registered)
module booth_result_bcd #(
    parameter int WORD_LENGTH = 16,
    parameter int DIGITS      = 10
) (
    input logic                clk,
    input logic                rst,
    booth_result_bcd_if.slave  bus
);
    localparam int PW = 2 * WORD_LENGTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = (PW > 2) ? $clog2(PW) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state_q, state_d;
    logic            ready_q;
    logic [PW-1:0]   mag_q, mag_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic [BW-1:0]   scr_adj;
    logic [BW-1:0]   scr_shift;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_pend_q, sign_pend_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            trigger;

    assign trigger = bus.mult_ready & ~ready_q;

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    always_comb begin
        scr_adj = scr_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
        scr_shift = {scr_adj[BW-2:0], mag_q[PW-1]};
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        scr_d       = scr_q;
        cnt_d       = cnt_q;
        sign_pend_d = sign_pend_q;
        bcd_d       = bcd_q;
        sign_d      = sign_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    // Most-negative value wraps back onto itself; read as unsigned it is correct.
                    mag_d       = bus.mult_result[PW-1] ? (~bus.mult_result + PW'(1))
                                                         : bus.mult_result;
                    sign_pend_d = bus.mult_result[PW-1];
                    scr_d       = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = CONV;
                end
            end
            CONV: begin
                scr_d = scr_shift;
                mag_d = {mag_q[PW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PW - 1)) begin
                    bcd_d   = scr_shift;
                    sign_d  = sign_pend_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;   // a level held through reset release must not trigger
            mag_q       <= '0;
            scr_q       <= '0;
            cnt_q       <= '0;
            sign_pend_q <= 1'b0;
            bcd_q       <= '0;
            sign_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= bus.mult_ready;
            mag_q       <= mag_d;
            scr_q       <= scr_d;
            cnt_q       <= cnt_d;
            sign_pend_q <= sign_pend_d;
            bcd_q       <= bcd_d;
            sign_q      <= sign_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.bcd  = bcd_q;
    assign bus.sign = sign_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_booth_result_bcd.sv
// tb_booth_result_bcd
//   Directed self-checking bench for booth_result_bcd with default
//   parameters (32-bit product, 10 BCD digits).
module tb_booth_result_bcd;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    booth_result_bcd_if #(.WORD_LENGTH(16), .DIGITS(10)) bus ();

    booth_result_bcd #(.WORD_LENGTH(16), .DIGITS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise mult_ready with value v, drop it after the trigger edge, then
    // follow the conversion to done and check latency, busy span and result.
    task automatic run(input logic [31:0] v, input logic [39:0] eb, input logic es, input string tag);
        int edges;
        int bcyc;
        bit both;
        @(negedge clk);
        bus.mult_result = v;
        bus.mult_ready  = 1'b1;
        edges = 0;
        bcyc  = 0;
        both  = 1'b0;
        do begin
            @(negedge clk);
            bus.mult_ready = 1'b0;
            edges++;
            if (bus.busy) bcyc++;
            if (bus.busy && bus.done) both = 1'b1;
        end while (!bus.done && edges < 100);
        check({tag, " latency"}, 64'(edges), 64'd33);
        check({tag, " busy_cycles"}, 64'(bcyc), 64'd32);
        check({tag, " bcd"}, 64'(bus.bcd), 64'(eb));
        check({tag, " sign"}, 64'(bus.sign), 64'(es));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, " busy_and_done"}, 64'(both), 64'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int edges;
        int dones;
        int busies;
        vectors     = 0;
        miscompares = 0;
        rst             = 1'b0;
        bus.mult_result = '0;
        bus.mult_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset bcd", 64'(bus.bcd), 64'd0);
        check("reset sign", 64'(bus.sign), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run(32'd100,      40'h0000000100, 1'b0, "p100");
        run(32'hFFFFFFFF, 40'h0000000001, 1'b1, "m1");
        run(32'h80000000, 40'h2147483648, 1'b1, "minneg");
        run(32'h7FFFFFFF, 40'h2147483647, 1'b0, "maxpos");
        run(32'd0,        40'h0000000000, 1'b0, "zero");

        // Second rising edge 10 cycles into a conversion must be ignored.
        @(negedge clk);
        bus.mult_result = 32'hFFFFFF85;   // -123
        bus.mult_ready  = 1'b1;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
            if (edges == 1) bus.mult_ready = 1'b0;
            if (edges == 10) begin
                bus.mult_result = 32'd999;
                bus.mult_ready  = 1'b1;
            end
            if (edges == 11) bus.mult_ready = 1'b0;
        end while (!bus.done && edges < 100);
        check("ignore latency", 64'(edges), 64'd33);
        check("ignore bcd", 64'(bus.bcd), 64'h123);
        check("ignore sign", 64'(bus.sign), 64'd1);
        dones = 0;
        busies = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busies++;
        end
        check("ignore extra_done", 64'(dones), 64'd0);
        check("ignore extra_busy", 64'(busies), 64'd0);
        run(32'd999, 40'h0000000999, 1'b0, "fresh999");

        // mult_ready held high for 100 cycles: exactly one conversion.
        @(negedge clk);
        bus.mult_result = 32'd4096;
        bus.mult_ready  = 1'b1;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        bus.mult_ready = 1'b0;
        check("held done_count", 64'(dones), 64'd1);
        check("held bcd", 64'(bus.bcd), 64'h4096);

        // mult_ready high across reset release: no conversion.
        @(negedge clk);
        rst            = 1'b0;
        bus.mult_ready = 1'b1;
        bus.mult_result = 32'd77;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        busies = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busies++;
        end
        check("rstheld done_count", 64'(dones), 64'd0);
        check("rstheld busy_count", 64'(busies), 64'd0);
        check("rstheld bcd", 64'(bus.bcd), 64'd0);
        bus.mult_ready = 1'b0;
        run(32'hFFFFFFFB, 40'h0000000005, 1'b1, "m5");

        // Reset at CONV iteration 15 aborts the conversion.
        @(negedge clk);
        bus.mult_result = 32'hFFFFFC18;   // -1000
        bus.mult_ready  = 1'b1;
        @(negedge clk);
        bus.mult_ready = 1'b0;
        check("midrst busy_before", 64'(bus.busy), 64'd1);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst bcd", 64'(bus.bcd), 64'd0);
        check("midrst sign", 64'(bus.sign), 64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        run(32'd12345, 40'h0000012345, 1'b0, "p12345");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
